// File: rtl/and_gate_bist.sv
// Purpose : built-in self-test for the and_gate lab DUT; sweeps {a,b} = 00,01,10,11 and checks y == a & b.
// Latency : result (done/pass/err_count/fail_vec) visible after 4*SETTLE_CYCLES*ROUNDS cycles from the accepted start.
// Backpress: none; start is ignored while busy, and results hold until the next accepted start.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start             begins a run when sampled high while not busy (IDLE or DONE)
//   a_o, b_o          stimulus driven into the DUT
//   y_i               DUT response, sampled at the end of each settle window
//   busy, done, pass  run status; pass = done with zero mismatches
//   err_count         saturating mismatch count for the run
//   fail_vec          bit i set if vector i = {a,b} ever mismatched
// Optional feature macro AND_GATE_BIST_FIRST_FAIL_EN adds first_fail_valid / first_fail_vec,
// capturing the vector index of the first mismatch of a run.
module and_gate_bist #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ROUNDS        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    input  logic       y_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [3:0] fail_vec
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
    ,
    output logic       first_fail_valid,
    output logic [1:0] first_fail_vec
`endif
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] ROUNDS_LAST = 8'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] vec, vec_nxt;
    logic [7:0] settle_cnt, settle_nxt;
    logic [7:0] round_cnt, round_nxt;
    logic [7:0] err_nxt;
    logic [3:0] fail_nxt;
    logic       a_nxt, b_nxt;
    logic       busy_nxt, done_nxt, pass_nxt;
    logic       mismatch;
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
    logic       ff_valid_nxt;
    logic [1:0] ff_vec_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= 2'd0;
            settle_cnt <= 8'd0;
            round_cnt  <= 8'd0;
            a_o        <= 1'b0;
            b_o        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 8'd0;
            fail_vec   <= 4'd0;
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 2'd0;
`endif
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            settle_cnt <= settle_nxt;
            round_cnt  <= round_nxt;
            a_o        <= a_nxt;
            b_o        <= b_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            err_count  <= err_nxt;
            fail_vec   <= fail_nxt;
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
            first_fail_valid <= ff_valid_nxt;
            first_fail_vec   <= ff_vec_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        vec_nxt    = vec;
        settle_nxt = settle_cnt;
        round_nxt  = round_cnt;
        a_nxt      = a_o;
        b_nxt      = b_o;
        err_nxt    = err_count;
        fail_nxt   = fail_vec;
        mismatch   = 1'b0;
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
        ff_valid_nxt = first_fail_valid;
        ff_vec_nxt   = first_fail_vec;
`endif

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt  = RUN;
                    vec_nxt    = 2'd0;
                    settle_nxt = SETTLE_LOAD;
                    round_nxt  = 8'd0;
                    a_nxt      = 1'b0;
                    b_nxt      = 1'b0;
                    err_nxt    = 8'd0;
                    fail_nxt   = 4'd0;
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
                    ff_valid_nxt = 1'b0;
                    ff_vec_nxt   = 2'd0;
`endif
                end
            end
            RUN: begin
                if (settle_cnt != 8'd0) begin
                    settle_nxt = settle_cnt - 8'd1;
                end else begin
                    // Compare against the registered stimulus, which is what the DUT sees.
                    mismatch = (y_i != (a_o & b_o));
                    if (mismatch) begin
                        if (err_count != 8'hFF) begin
                            err_nxt = err_count + 8'd1;
                        end
                        fail_nxt[vec] = 1'b1;
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
                        if (!first_fail_valid) begin
                            ff_valid_nxt = 1'b1;
                            ff_vec_nxt   = vec;
                        end
`endif
                    end
                    settle_nxt = SETTLE_LOAD;
                    // vec wraps 3 -> 0, which also parks a_o/b_o at 0 on completion.
                    vec_nxt = vec + 2'd1;
                    a_nxt   = vec_nxt[1];
                    b_nxt   = vec_nxt[0];
                    if (vec == 2'd3) begin
                        round_nxt = round_cnt + 8'd1;
                        if (round_nxt == ROUNDS_LAST) begin
                            state_nxt = DONE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
        pass_nxt = done_nxt && (err_nxt == 8'd0);
    end

endmodule

// File: tb/tb_and_gate_bist.sv
module tb_and_gate_bist;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Three engines with different parameters; each sees its own faulty/healthy DUT model,
    // expressed as a 4-entry truth table indexed by {a,b}.
    logic       start_s [3];
    logic       a_s     [3];
    logic       b_s     [3];
    logic       busy_s  [3];
    logic       done_s  [3];
    logic       pass_s  [3];
    logic [7:0] err_s   [3];
    logic [3:0] fv_s    [3];
    logic [3:0] lut     [3];
    logic       y0, y1, y2;
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
    logic       ffv_s   [3];
    logic [1:0] ffvec_s [3];
`endif

    assign y0 = lut[0][{a_s[0], b_s[0]}];
    assign y1 = lut[1][{a_s[1], b_s[1]}];
    assign y2 = lut[2][{a_s[2], b_s[2]}];

    and_gate_bist #(.SETTLE_CYCLES(2), .ROUNDS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a_o(a_s[0]), .b_o(b_s[0]), .y_i(y0),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]), .fail_vec(fv_s[0])
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
        , .first_fail_valid(ffv_s[0]), .first_fail_vec(ffvec_s[0])
`endif
    );

    and_gate_bist #(.SETTLE_CYCLES(1), .ROUNDS(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a_o(a_s[1]), .b_o(b_s[1]), .y_i(y1),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err_s[1]), .fail_vec(fv_s[1])
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
        , .first_fail_valid(ffv_s[1]), .first_fail_vec(ffvec_s[1])
`endif
    );

    and_gate_bist #(.SETTLE_CYCLES(1), .ROUNDS(100)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .a_o(a_s[2]), .b_o(b_s[2]), .y_i(y2),
        .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(err_s[2]), .fail_vec(fv_s[2])
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
        , .first_fail_valid(ffv_s[2]), .first_fail_vec(ffvec_s[2])
`endif
    );

    int tests = 0;
    int fails = 0;

    function automatic int settle_of(input int idx);
        return (idx == 0) ? 2 : 1;
    endfunction

    function automatic int rounds_of(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 3 : 100);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk every round and vector, count where the DUT truth table disagrees with AND.
    function automatic void model(input logic [3:0] l, input int rounds,
                                  output int err, output logic [3:0] fv, output int first);
        err   = 0;
        fv    = 4'd0;
        first = -1;
        for (int r = 0; r < rounds; r++) begin
            for (int v = 0; v < 4; v++) begin
                if (l[v] != (v == 3)) begin
                    err++;
                    fv[v] = 1'b1;
                    if (first < 0) first = v;
                end
            end
        end
        if (err > 255) err = 255;
    endfunction

    // One complete run: start, follow the stimulus sequence, check final results.
    // restart_at > 0 additionally raises start so it is sampled at edge S+restart_at.
    task automatic run(input int idx, input logic [3:0] l, input int exp_err,
                       input logic [3:0] exp_fv, input int exp_first,
                       input int restart_at, input string tag);
        int  n;
        int  sc;
        int  exp_cycles;
        bit  seq_ok;
        bit  excl_ok;
        sc         = settle_of(idx);
        exp_cycles = 4 * sc * rounds_of(idx);
        lut[idx]   = l;
        @(negedge clk);
        start_s[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_s[idx] = 1'b0;
        chk({tag, " busy after start"}, int'(busy_s[idx]), 1);
        chk({tag, " done cleared at start"}, int'(done_s[idx]), 0);
        chk({tag, " err cleared at start"}, int'(err_s[idx]), 0);
        chk({tag, " fail_vec cleared at start"}, int'(fv_s[idx]), 0);
        chk({tag, " first vector"}, int'({a_s[idx], b_s[idx]}), 0);
        n       = 0;
        seq_ok  = 1'b1;
        excl_ok = 1'b1;
        while (n < 50000) begin
            if (restart_at > 0 && n == restart_at - 1) start_s[idx] = 1'b1;
            @(posedge clk);
            n++;
            #1;
            start_s[idx] = 1'b0;
            if (busy_s[idx] && done_s[idx]) excl_ok = 1'b0;
            if (done_s[idx]) break;
            if (int'({a_s[idx], b_s[idx]}) != (n / sc) % 4) seq_ok = 1'b0;
        end
        chk({tag, " cycles to done"}, n, exp_cycles);
        chk({tag, " vector sequence ok"}, int'(seq_ok), 1);
        chk({tag, " busy/done exclusive"}, int'(excl_ok), 1);
        chk({tag, " busy at done"}, int'(busy_s[idx]), 0);
        chk({tag, " err_count"}, int'(err_s[idx]), exp_err);
        chk({tag, " fail_vec"}, int'(fv_s[idx]), int'(exp_fv));
        chk({tag, " pass"}, int'(pass_s[idx]), (exp_err == 0) ? 1 : 0);
        chk({tag, " ab parked"}, int'({a_s[idx], b_s[idx]}), 0);
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
        chk({tag, " first_fail_valid"}, int'(ffv_s[idx]), (exp_first >= 0) ? 1 : 0);
        chk({tag, " first_fail_vec"}, int'(ffvec_s[idx]), (exp_first >= 0) ? exp_first : 0);
`else
        if (exp_first < -1) $display("unexpected first index %0d", exp_first);
`endif
    endtask

    typedef struct {
        logic [3:0] l;
        int         exp_err;
        logic [3:0] exp_fv;
        int         exp_first;
        string      name;
    } vec_t;

    initial begin
        vec_t tbl [5];
        int   m_err;
        int   m_first;
        logic [3:0] m_fv;
        logic [3:0] rl;

        tbl[0] = '{4'b1000, 0, 4'b0000, -1, "and_ok"};
        tbl[1] = '{4'b0000, 1, 4'b1000,  3, "stuck0"};
        tbl[2] = '{4'b1111, 3, 4'b0111,  0, "stuck1"};
        tbl[3] = '{4'b0110, 3, 4'b1110,  1, "xor"};
        tbl[4] = '{4'b1001, 1, 4'b0001,  0, "xnor"};

        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            lut[i]     = 4'b1000;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy_s[0]), 0);
        chk("reset done", int'(done_s[0]), 0);
        chk("reset pass", int'(pass_s[0]), 0);
        chk("reset err", int'(err_s[0]), 0);
        chk("reset fail_vec", int'(fv_s[0]), 0);
        chk("reset ab", int'({a_s[0], b_s[0]}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run(0, tbl[i].l, tbl[i].exp_err, tbl[i].exp_fv, tbl[i].exp_first, 0, tbl[i].name);
        end

        // Start during RUN must be ignored; the run before left nonzero errors in DONE,
        // so this run also shows a start from DONE clearing the previous results.
        run(0, 4'b1000, 0, 4'b0000, -1, 3, "restart_ignored");
        run(0, 4'b0000, 1, 4'b1000, 3, 0, "rerun_from_done");

        run(1, 4'b1111, 9, 4'b0111, 0, 0, "stuck1_r3_s1");
        run(2, 4'b1111, 255, 4'b0111, 0, 0, "saturate_r100");

        for (int k = 0; k < 6; k++) begin
            rl = 4'($urandom_range(0, 15));
            model(rl, rounds_of(0), m_err, m_fv, m_first);
            run(0, rl, m_err, m_fv, m_first, 0, $sformatf("rand_u0_%0d", k));
            rl = 4'($urandom_range(0, 15));
            model(rl, rounds_of(1), m_err, m_fv, m_first);
            run(1, rl, m_err, m_fv, m_first, 0, $sformatf("rand_u1_%0d", k));
        end

        // Asynchronous reset in the middle of a failing run.
        lut[0] = 4'b1111;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre-reset busy", int'(busy_s[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("async reset busy", int'(busy_s[0]), 0);
        chk("async reset done", int'(done_s[0]), 0);
        chk("async reset pass", int'(pass_s[0]), 0);
        chk("async reset err", int'(err_s[0]), 0);
        chk("async reset fail_vec", int'(fv_s[0]), 0);
        chk("async reset ab", int'({a_s[0], b_s[0]}), 0);
`ifdef AND_GATE_BIST_FIRST_FAIL_EN
        chk("async reset first_fail_valid", int'(ffv_s[0]), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle after reset busy", int'(busy_s[0]), 0);
        chk("idle after reset done", int'(done_s[0]), 0);
        run(0, 4'b1000, 0, 4'b0000, -1, 0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
